// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Iterative MIPS-style HI/LO multiply/divide unit. One
//                shift-add (mult) or restoring shift-subtract (div) step per
//                cycle on operand magnitudes, then a single sign-fixup cycle.
//                The divider datapath and DIV/DIVU sequencing are present only
//                when the macro MULDIV_DIV_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int DATA_BUS_WIDTH = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [1:0]                i_op,
    input  logic [DATA_BUS_WIDTH-1:0] i_a,
    input  logic [DATA_BUS_WIDTH-1:0] i_b,
    input  logic                      i_flush,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [DATA_BUS_WIDTH-1:0] o_hi,
    output logic [DATA_BUS_WIDTH-1:0] o_lo
);

    localparam int W        = DATA_BUS_WIDTH;
    localparam int DIV_ITER = DATA_BUS_WIDTH;

    localparam logic [5:0] c_LAST_ITER = 6'(DIV_ITER - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_SIGN = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [5:0]     cnt_q,   cnt_d;
    logic           neg_q,   neg_d;    // negate product / quotient in SIGN
    logic [W-1:0]   opnd_q,  opnd_d;   // |a| addend (mult) or |b| divisor (div)
    logic [2*W-1:0] acc_q,   acc_d;    // {hi, lo} working register
    logic [W-1:0]   hi_q,    hi_d;
    logic [W-1:0]   lo_q,    lo_d;
    logic           busy_q,  busy_d;
    logic           done_q,  done_d;
`ifdef MULDIV_DIV_EN
    logic           div_q,   div_d;    // current op is a divide
    logic           rneg_q,  rneg_d;   // remainder takes dividend sign
    logic           divz_q,  divz_d;   // divisor was zero
    logic [W-1:0]   a_q,     a_d;      // raw dividend for divide-by-zero result
`endif

    logic           w_signed;
    logic           w_neg_start;
    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic [W:0]     w_sum;
    logic [W:0]     w_add;
    logic [2*W-1:0] w_prod;
`ifdef MULDIV_DIV_EN
    logic [W:0]     w_trial;
    logic [W:0]     w_diff;
    logic [W-1:0]   w_quo;
    logic [W-1:0]   w_rem;
`endif

    // Operand magnitudes and datapath arithmetic shared by the FSM
    assign w_signed    = ~i_op[0];
    assign w_neg_start = w_signed & (i_a[W-1] ^ i_b[W-1]);
    assign w_mag_a     = (w_signed && i_a[W-1]) ? -i_a : i_a;
    assign w_mag_b     = (w_signed && i_b[W-1]) ? -i_b : i_b;
    assign w_sum       = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
    assign w_add       = acc_q[0] ? w_sum : {1'b0, acc_q[2*W-1:W]};
    assign w_prod      = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
    // Restoring step: shift {rem, quo} left one and trial-subtract the divisor
    assign w_trial     = acc_q[2*W-1:W-1];
    assign w_diff      = w_trial - {1'b0, opnd_q};
    assign w_quo       = neg_q  ? -acc_q[W-1:0]     : acc_q[W-1:0];
    assign w_rem       = rneg_q ? -acc_q[2*W-1:W]   : acc_q[2*W-1:W];
`endif

    // Next-state and datapath sequencing; flush overrides everything but reset
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
        div_d   = div_q;
        rneg_d  = rneg_q;
        divz_d  = divz_q;
        a_d     = a_q;
`endif
        case (state_q)
            c_IDLE: begin
                if (i_start) begin
                    state_d = c_CALC;
                    busy_d  = 1'b1;
                    cnt_d   = 6'd0;
                    neg_d   = w_neg_start;
                    opnd_d  = w_mag_a;
                    acc_d   = {{W{1'b0}}, w_mag_b};
`ifdef MULDIV_DIV_EN
                    div_d   = i_op[1];
                    rneg_d  = w_signed & i_a[W-1];
                    divz_d  = (i_b == '0);
                    a_d     = i_a;
                    if (i_op[1]) begin
                        opnd_d = w_mag_b;
                        acc_d  = {{W{1'b0}}, w_mag_a};
                    end
`else
                    // Divide not built: acknowledge immediately, results untouched
                    if (i_op[1]) begin
                        state_d = c_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
            c_CALC: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q + 6'd1;
                acc_d  = {w_add, acc_q[W-1:1]};
`ifdef MULDIV_DIV_EN
                if (div_q) begin
                    acc_d = w_diff[W] ? {w_trial[W-1:0], acc_q[W-2:0], 1'b0}
                                      : {w_diff[W-1:0],  acc_q[W-2:0], 1'b1};
                end
`endif
                if (cnt_q == c_LAST_ITER) begin
                    state_d = c_SIGN;
                    cnt_d   = 6'd0;
                end
            end
            c_SIGN: begin
                state_d = c_DONE;
                done_d  = 1'b1;
                hi_d    = w_prod[2*W-1:W];
                lo_d    = w_prod[W-1:0];
`ifdef MULDIV_DIV_EN
                if (div_q) begin
                    if (divz_q) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = w_rem;
                        lo_d = w_quo;
                    end
                end
`endif
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        if (i_flush) begin
            state_d = c_IDLE;
            cnt_d   = 6'd0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= c_IDLE;
            cnt_q   <= 6'd0;
            neg_q   <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_q   <= 1'b0;
            rneg_q  <= 1'b0;
            divz_q  <= 1'b0;
            a_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MULDIV_DIV_EN
            div_q   <= div_d;
            rneg_q  <= rneg_d;
            divz_q  <= divz_d;
            a_q     <= a_d;
`endif
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_sequencer
//  Description : Self-checking bench for muldiv_sequencer. A timeline model
//                computes results with 64-bit arithmetic and is compared with
//                the DUT every cycle; directed cases pin literal results.
//                Honours MULDIV_DIV_EN the same way the design does.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

`ifdef MULDIV_DIV_EN
    localparam bit c_DIV_EN = 1'b1;
`else
    localparam bit c_DIV_EN = 1'b0;
`endif
    localparam int c_LAT     = 34;
    localparam int c_LAT_DIV = c_DIV_EN ? 34 : 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state: cycles left until the done cycle, pending result, outputs
    int          m_left = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_pend = '0;

    muldiv_sequencer #(.DATA_BUS_WIDTH(32)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_start (start),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .i_flush (flush),
        .o_busy  (busy),
        .o_done  (done),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} from plain arithmetic
    function automatic logic [63:0] ref_calc(input logic [1:0] f_op, input logic [31:0] fa, input logic [31:0] fb);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] m;
        logic [63:0]        r;
        sa = 64'(signed'(fa));
        sb = 64'(signed'(fb));
        r  = '0;
        case (f_op)
            2'b00: r = sa * sb;
            2'b01: r = {32'd0, fa} * {32'd0, fb};
            2'b10: begin
                if (fb == 32'd0) r = {fa, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
            default: begin
                if (fb == 32'd0) r = {fa, 32'hFFFF_FFFF};
                else r = {fa % fb, fa / fb};
            end
        endcase
        return r;
    endfunction

    // Reference timeline: accept in idle, done c_LAT cycles later
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst) begin
            m_left <= 0;
            m_busy <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (flush) begin
            m_left <= 0;
            m_busy <= 1'b0;
        end else if (m_left == 0) begin
            if (start && !m_done) begin
                if (op[1] && !c_DIV_EN) begin
                    m_done <= 1'b1;
                end else begin
                    m_left <= c_LAT - 1;
                    m_busy <= 1'b1;
                    m_pend <= ref_calc(op, a, b);
                end
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_hi   <= m_pend[63:32];
                m_lo   <= m_pend[31:0];
            end
        end
    end

    // Every-cycle comparison of DUT against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc busy", 64'(busy), 64'(m_busy));
            check("cyc done", 64'(done), 64'(m_done));
            check("cyc hi",   64'(hi),   64'(m_hi));
            check("cyc lo",   64'(lo),   64'(m_lo));
        end
    end

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Issue one operation and wait (bounded) for its done pulse
    task automatic run_op(input logic [1:0] t_op, input logic [31:0] ta, input logic [31:0] tb_, output int lat);
        @(negedge clk);
        start = 1'b1;
        op    = t_op;
        a     = ta;
        b     = tb_;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_check(input string name, input logic [1:0] t_op, input logic [31:0] ta,
                             input logic [31:0] tb_, input int exp_lat,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        run_op(t_op, ta, tb_, lat);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " hi"}, 64'(hi), 64'(exp_hi));
        check({name, " lo"}, 64'(lo), 64'(exp_lo));
        check({name, " model hi"}, 64'(m_hi), 64'(exp_hi));
        check({name, " model lo"}, 64'(m_lo), 64'(exp_lo));
    endtask

    initial begin
        bit seen;
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi",   64'(hi),   64'd0);
        check("reset lo",   64'(lo),   64'd0);
        rst = 1'b0;

        run_check("MULTU max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c_LAT, 32'hFFFF_FFFE, 32'h0000_0001);
        run_check("MULT -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7, c_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_check("DIV -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, c_LAT_DIV,
                  32'hFFFF_FFFF, c_DIV_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFEB);
        run_check("DIVU 100/0", 2'b11, 32'd100, 32'd0, c_LAT_DIV,
                  c_DIV_EN ? 32'd100 : 32'hFFFF_FFFF, c_DIV_EN ? 32'hFFFF_FFFF : 32'hFFFF_FFEB);
        run_check("DIV ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, c_LAT_DIV,
                  c_DIV_EN ? 32'd0 : 32'hFFFF_FFFF, c_DIV_EN ? 32'h8000_0000 : 32'hFFFF_FFEB);
        run_check("DIV 9/3", 2'b10, 32'd9, 32'd3, c_LAT_DIV,
                  c_DIV_EN ? 32'd0 : 32'hFFFF_FFFF, c_DIV_EN ? 32'd3 : 32'hFFFF_FFEB);
        check("DIV 9/3 busy", 64'(busy), 64'd0);
        run_check("MULTU 5*6", 2'b01, 32'd5, 32'd6, c_LAT, 32'd0, 32'd30);

        // Flush in CALC cycle 10 with a simultaneous start
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd1234; b = 32'hFFFF_0000;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush pre busy", 64'(busy), 64'd1);
        flush = 1'b1; start = 1'b1; op = 2'b01;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush done", 64'(done), 64'd0);
        check("flush hi", 64'(hi), 64'd0);
        check("flush lo", 64'(lo), 64'd30);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("flush no done", 64'(seen), 64'd0);
        check("flush keep lo", 64'(lo), 64'd30);

        // Reset in CALC cycle 20, then a fresh operation
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd1234; b = 32'd5678;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        check("midreset hi", 64'(hi), 64'd0);
        check("midreset lo", 64'(lo), 64'd0);
        run_check("MULT min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, c_LAT, 32'h4000_0000, 32'd0);
        run_check("MULT b2b", 2'b00, 32'd7, 32'hFFFF_FFFF, c_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF9);

        // Randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 79) == 0);
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = rnd_opnd();
            b     = rnd_opnd();
        end
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; start = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
